// File: rtl/tmem_pkg.sv
// rtl/tmem_pkg.sv - shared types and constants for the tagged-memory controller
package tmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        CHECK = 2'd2,
        WRITE = 2'd3
    } state_e;

    localparam int              ADDR_W_DEF  = 20;
    localparam int              DATA_W      = 64;
    localparam int              TAG_W       = 8;
    localparam logic [TAG_W-1:0] WP_MASK_DEF = 8'h80;

    // A stored tag marks its word read-only when any masked bit is set.
    function automatic logic tag_protected(input logic [TAG_W-1:0] tag,
                                           input logic [TAG_W-1:0] mask);
        return (tag & mask) != '0;
    endfunction

endpackage

// File: rtl/tmem_array.sv
// rtl/tmem_array.sv - behavioural tagged RAM with a configurable read pipeline
module tmem_array
    import tmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              re,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [TAG_W-1:0]  wtag,
    output logic [DATA_W-1:0] rdata,
    output logic [TAG_W-1:0]  rtag
);

    localparam int WORD_W = DATA_W + TAG_W;

    logic [WORD_W-1:0] mem  [0:(1<<ADDR_W)-1];
    logic [WORD_W-1:0] pipe [RD_LAT];

    // Word store plus read pipeline; output is valid RD_LAT cycles after re.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= {wtag, wdata};
        end
        if (re) begin
            pipe[0] <= mem[addr];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign rdata = pipe[RD_LAT-1][DATA_W-1:0];
    assign rtag  = pipe[RD_LAT-1][WORD_W-1:DATA_W];

endmodule

// File: rtl/tmem_ctrl.sv
// rtl/tmem_ctrl.sv - CPU bus to tagged RAM controller with tag write protection
module tmem_ctrl
    import tmem_pkg::*;
#(
    parameter int               ADDR_W  = ADDR_W_DEF,
    parameter int               RD_LAT  = 1,
    parameter logic [TAG_W-1:0] WP_MASK = WP_MASK_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_ad,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_astb,
    input  logic              i_atomic,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic              i_wforce,
    output logic [DATA_W-1:0] o_data,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_busy,
    output logic              o_wfault,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_re,
    output logic              m_we,
    output logic [DATA_W-1:0] m_wdata,
    output logic [TAG_W-1:0]  m_wtag,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [TAG_W-1:0]  m_rtag
);

    // Counter loads: RWAIT starts one cycle after the strobe, CHECK issues its own.
    localparam logic [2:0] LAT    = 3'(RD_LAT);
    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              atomic_q,  atomic_d;
    logic              tvalid_q,  tvalid_d;
    logic [TAG_W-1:0]  old_tag_q, old_tag_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [TAG_W-1:0]  wtag_q,    wtag_d;
    logic [2:0]        cnt_q,     cnt_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic [TAG_W-1:0]  tag_q,     tag_d;
    logic              busy_q,    busy_d;
    logic              wfault_q,  wfault_d;
    logic              we_q,      we_d;

    // Next-state and datapath decisions for the access sequencer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        atomic_d  = atomic_q;
        tvalid_d  = tvalid_q;
        old_tag_d = old_tag_q;
        wdata_d   = wdata_q;
        wtag_d    = wtag_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        tag_d     = tag_q;
        busy_d    = busy_q;
        wfault_d  = 1'b0;
        we_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_astb) begin
                    addr_d   = i_ad[ADDR_W-1:0];
                    atomic_d = i_atomic;
                    tvalid_d = 1'b0;
                end else if (i_wr) begin
                    wdata_d = i_ad;
                    wtag_d  = i_tag;
                    if (i_wforce || (tvalid_q && !tag_protected(old_tag_q, WP_MASK))) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        busy_d  = 1'b1;
                    end else if (tvalid_q) begin
                        // Saved tag already says protected: refuse without touching the array.
                        wfault_d = 1'b1;
                    end else begin
                        state_d = CHECK;
                        cnt_d   = LAT;
                        busy_d  = 1'b1;
                    end
                end else if (i_rd) begin
                    state_d = RWAIT;
                    cnt_d   = LAT_M1;
                    busy_d  = 1'b1;
                end
            end
            RWAIT: begin
                if (cnt_q == 3'd0) begin
                    data_d  = m_rdata;
                    tag_d   = m_rtag;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (atomic_q) begin
                        old_tag_d = m_rtag;
                        tvalid_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            CHECK: begin
                if (cnt_q == 3'd0) begin
                    if (tag_protected(m_rtag, WP_MASK)) begin
                        wfault_d = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WRITE: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                tvalid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            atomic_q  <= 1'b0;
            tvalid_q  <= 1'b0;
            old_tag_q <= '0;
            wdata_q   <= '0;
            wtag_q    <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            tag_q     <= '0;
            busy_q    <= 1'b0;
            wfault_q  <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            atomic_q  <= atomic_d;
            tvalid_q  <= tvalid_d;
            old_tag_q <= old_tag_d;
            wdata_q   <= wdata_d;
            wtag_q    <= wtag_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            busy_q    <= busy_d;
            wfault_q  <= wfault_d;
            we_q      <= we_d;
        end
    end

    // Read strobe goes out in the request cycle so data lands RD_LAT+1 cycles after rd.
    assign m_re = ~reset & (((state_q == IDLE) & i_rd & ~i_wr & ~i_astb) |
                            ((state_q == CHECK) & (cnt_q == LAT)));

    assign m_we     = we_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign m_wtag   = wtag_q;
    assign o_data   = data_q;
    assign o_tag    = tag_q;
    assign o_busy   = busy_q;
    assign o_wfault = wfault_q;

endmodule

// File: tb/tb_tmem_ctrl.sv
// tb/tb_tmem_ctrl.sv - randomized self-checking bench for tmem_ctrl
module tb_tmem_ctrl;

    localparam int         ADDR_W = 12;
    localparam int         RD_LAT = 3;
    localparam logic [7:0] WPM    = 8'h80;

    logic              clk = 1'b0;
    logic              reset;
    logic [63:0]       i_ad;
    logic [7:0]        i_tag;
    logic              i_astb, i_atomic, i_rd, i_wr, i_wforce;
    logic [63:0]       o_data;
    logic [7:0]        o_tag;
    logic              o_busy, o_wfault;
    logic [ADDR_W-1:0] m_addr;
    logic              m_re, m_we;
    logic [63:0]       m_wdata, m_rdata;
    logic [7:0]        m_wtag, m_rtag;

    tmem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WP_MASK(WPM)) dut (
        .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
        .i_atomic(i_atomic), .i_rd(i_rd), .i_wr(i_wr), .i_wforce(i_wforce),
        .o_data(o_data), .o_tag(o_tag), .o_busy(o_busy), .o_wfault(o_wfault),
        .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wdata(m_wdata), .m_wtag(m_wtag),
        .m_rdata(m_rdata), .m_rtag(m_rtag)
    );

    tmem_array #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_mem (
        .clk(clk), .addr(m_addr), .re(m_re), .we(m_we), .wdata(m_wdata), .wtag(m_wtag),
        .rdata(m_rdata), .rtag(m_rtag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Array-side monitor.
    int          n_re = 0, n_we = 0, n_both = 0;
    logic [11:0] we_addr;
    logic [71:0] we_word;
    always @(posedge clk) begin
        if (m_re) n_re <= n_re + 1;
        if (m_we) begin
            n_we    <= n_we + 1;
            we_addr <= m_addr;
            we_word <= {m_wtag, m_wdata};
        end
        if (m_re && m_we) n_both <= n_both + 1;
    end

    // Reference model: latched address/flags, saved tag, word contents, read result.
    bit [ADDR_W-1:0] maddr;
    bit              matomic, mtvalid;
    bit [7:0]        msaved;
    bit [71:0]       mmem [int];
    bit [71:0]       mout;

    task automatic expect_eq(input string name, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic clear_inputs();
        i_rd = 1'b0; i_wr = 1'b0; i_astb = 1'b0; i_wforce = 1'b0; i_atomic = 1'b0;
    endtask

    // Entered at the first negedge after a request; returns cycles until o_busy low.
    task automatic wait_done(input bit junk, output int lat, output int faults);
        lat = 1;
        faults = 0;
        while (1) begin
            faults += int'(o_wfault);
            if (!o_busy || lat >= 40) break;
            if (junk) begin
                i_rd   = 1'($urandom);
                i_wr   = 1'($urandom);
                i_astb = 1'($urandom);
                i_ad   = {$urandom, $urandom};
            end
            @(negedge clk);
            lat++;
        end
        clear_inputs();
        if (o_busy) expect_eq("busy_timeout", 72'(o_busy), 72'd0);
    endtask

    task automatic do_astb(input bit [ADDR_W-1:0] addr, input bit atomic, input bit with_rd);
        int re0;
        re0 = n_re;
        i_ad = {$urandom, $urandom};
        i_ad[ADDR_W-1:0] = addr;
        i_astb = 1'b1; i_atomic = atomic; i_rd = with_rd;
        #1 expect_eq("astb_re_now", 72'(m_re), 72'd0);
        @(negedge clk);
        clear_inputs();
        expect_eq("astb_busy", 72'(o_busy), 72'd0);
        expect_eq("astb_re_cnt", 72'(n_re - re0), 72'd0);
        maddr = addr; matomic = atomic; mtvalid = 1'b0;
    endtask

    task automatic do_rd(input bit junk);
        int re0, we0, lat, flt;
        bit [71:0] exp;
        exp = mmem[int'(maddr)];
        re0 = n_re; we0 = n_we;
        i_rd = 1'b1;
        #1 expect_eq("rd_re_now", 72'(m_re), 72'd1);
        expect_eq("rd_addr", 72'(m_addr), 72'(maddr));
        @(negedge clk);
        i_rd = 1'b0;
        wait_done(junk, lat, flt);
        expect_eq("rd_lat", 72'(lat), 72'(RD_LAT + 1));
        expect_eq("rd_word", {o_tag, o_data}, exp);
        expect_eq("rd_re_cnt", 72'(n_re - re0), 72'd1);
        expect_eq("rd_we_cnt", 72'(n_we - we0), 72'd0);
        expect_eq("rd_fault", 72'(flt), 72'd0);
        if (matomic) begin
            mtvalid = 1'b1;
            msaved  = exp[71:64];
        end
        mout = exp;
    endtask

    task automatic do_wr(input bit [63:0] data, input bit [7:0] tag, input bit force_w,
                         input bit with_rd, input bit junk);
        int re0, we0, lat, flt, exp_lat, exp_re;
        bit refuse;
        re0 = n_re; we0 = n_we;
        if (force_w || (mtvalid && (msaved & WPM) == 8'h00)) begin
            refuse = 1'b0; exp_lat = 2; exp_re = 0;
        end else if (mtvalid) begin
            refuse = 1'b1; exp_lat = 1; exp_re = 0;
        end else begin
            refuse  = (mmem[int'(maddr)][71:64] & WPM) != 8'h00;
            exp_lat = refuse ? RD_LAT + 2 : RD_LAT + 3;
            exp_re  = 1;
        end
        i_wr = 1'b1; i_ad = data; i_tag = tag; i_wforce = force_w; i_rd = with_rd;
        #1 expect_eq("wr_re_now", 72'(m_re), 72'd0);
        @(negedge clk);
        clear_inputs();
        wait_done(junk, lat, flt);
        expect_eq("wr_lat", 72'(lat), 72'(exp_lat));
        expect_eq("wr_fault", 72'(flt), 72'(refuse));
        expect_eq("wr_re_cnt", 72'(n_re - re0), 72'(exp_re));
        expect_eq("wr_we_cnt", 72'(n_we - we0), 72'(!refuse));
        expect_eq("wr_rd_hold", {o_tag, o_data}, mout);
        if (!refuse) begin
            expect_eq("wr_addr", 72'(we_addr), 72'(maddr));
            expect_eq("wr_word", we_word, {tag, data});
            mmem[int'(maddr)] = {tag, data};
            mtvalid = 1'b0;
        end
    endtask

    bit [7:0] tags [5] = '{8'h00, 8'h80, 8'h05, 8'h85, 8'h7F};

    initial begin
        int re0, we0;
        reset = 1'b1;
        i_ad = '0; i_tag = '0;
        clear_inputs();
        repeat (3) @(negedge clk);
        expect_eq("rst_data", 72'(o_data), 72'd0);
        expect_eq("rst_tag", 72'(o_tag), 72'd0);
        expect_eq("rst_busy", 72'(o_busy), 72'd0);
        expect_eq("rst_wfault", 72'(o_wfault), 72'd0);
        expect_eq("rst_re", 72'(m_re), 72'd0);
        expect_eq("rst_we", 72'(m_we), 72'd0);
        expect_eq("rst_addr", 72'(m_addr), 72'd0);
        reset = 1'b0;
        maddr = '0; matomic = 1'b0; mtvalid = 1'b0; msaved = '0; mout = '0;

        // Known contents for every address used below.
        do_astb(12'h100, 1'b0, 1'b0); do_wr(64'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        do_astb(12'h300, 1'b0, 1'b0); do_wr({$urandom, $urandom}, 8'h05, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_astb(12'h040 + 12'(i), 1'b0, 1'b0);
            do_wr({$urandom, $urandom}, tags[$urandom % 5], 1'b1, 1'b0, 1'b0);
        end

        // Checked write then read-back.
        do_astb(12'h100, 1'b0, 1'b0);
        do_wr(64'h0123_4567_89AB_CDEF, 8'h02, 1'b0, 1'b0, 1'b0);
        do_rd(1'b0);

        // Protected word: refused, then forced.
        do_astb(12'h200, 1'b0, 1'b0); do_wr(64'hDEAD, 8'h80, 1'b1, 1'b0, 1'b0);
        do_astb(12'h200, 1'b0, 1'b0);
        do_wr(64'h1, 8'h00, 1'b0, 1'b0, 1'b0);
        do_rd(1'b0);
        do_wr(64'h1, 8'h00, 1'b1, 1'b0, 1'b0);
        do_rd(1'b0);

        // Atomic sequence reuses the tag it read.
        re0 = n_re;
        do_astb(12'h300, 1'b1, 1'b0);
        do_rd(1'b0);
        do_wr(64'hFF, 8'h05, 1'b0, 1'b0, 1'b0);
        expect_eq("atomic_re_total", 72'(n_re - re0), 72'd1);

        // rd+wr together, requests during busy, rd with astb.
        do_astb(12'h100, 1'b0, 1'b1);
        do_wr({$urandom, $urandom}, 8'h00, 1'b0, 1'b1, 1'b1);
        do_rd(1'b1);

        // Reset in the middle of a read wait.
        i_rd = 1'b1;
        @(negedge clk);
        i_rd = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        expect_eq("mid_rst_busy", 72'(o_busy), 72'd0);
        expect_eq("mid_rst_word", {o_tag, o_data}, 72'd0);
        expect_eq("mid_rst_wfault", 72'(o_wfault), 72'd0);
        expect_eq("mid_rst_strobes", {70'd0, m_re, m_we}, 72'd0);
        reset = 1'b0;
        re0 = n_re; we0 = n_we;
        repeat (6) @(negedge clk);
        expect_eq("post_rst_re", 72'(n_re - re0), 72'd0);
        expect_eq("post_rst_we", 72'(n_we - we0), 72'd0);
        maddr = '0; matomic = 1'b0; mtvalid = 1'b0; mout = '0;
        do_astb(12'h100, 1'b0, 1'b0);
        do_rd(1'b0);

        // Random mix over the preloaded pool.
        for (int n = 0; n < 80; n++) begin
            case ($urandom % 4)
                0: do_astb(12'h040 + 12'($urandom % 8), 1'($urandom), 1'($urandom));
                1: do_rd(1'b1);
                default: do_wr({$urandom, $urandom}, tags[$urandom % 5],
                               ($urandom % 4) == 0, 1'($urandom), 1'b1);
            endcase
        end

        expect_eq("re_we_overlap", 72'(n_both), 72'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
